bip_program_loader: RTL and testbench

//  Upstream feeder of the BIP I CPU instruction port. It receives a program as a

---
 rtl/bip_loader_pkg.sv | 20 ++
 rtl/bip_prog_ram.sv | 26 ++
 rtl/bip_program_loader.sv | 177 +++++++++++++++++
 tb/tb_bip_program_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_loader_pkg.sv
// Shared constants and state encoding for the BIP I program loader.
package bip_loader_pkg;

    localparam int unsigned ADDR_W_DEF = 11;
    localparam int unsigned DATA_W_DEF = 16;

    localparam logic [7:0] START_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CHECK   = 3'd5,
        ST_RUN     = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

endpackage

// File: rtl/bip_prog_ram.sv
// Program memory: one synchronous write port, one asynchronous read port, no reset.
module bip_prog_ram
    import bip_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bip_program_loader.sv
// Loads a framed byte stream into program memory, holds the CPU while loading,
// and serves instructions once a frame with a valid checksum has been accepted.
module bip_program_loader
    import bip_loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [7:0]        Rx_Data,
    input  logic              Rx_Valid,
    input  logic [ADDR_W-1:0] InsAddr,
    output logic [DATA_W-1:0] Instruction,
    output logic              Cpu_Hold,
    output logic              Load_Done,
    output logic              Load_Error,
    output logic [ADDR_W:0]   Words_Loaded
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [15:0]       len, len_nxt;
    logic [7:0]        hi_byte, hi_nxt;
    logic [7:0]        csum, csum_nxt;
    logic [CNT_W-1:0]  wr_addr, wr_addr_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic              hold_nxt, done_nxt, err_nxt;
    logic [CNT_W-1:0]  words_nxt;

    logic              ram_we_c;
    logic [DATA_W-1:0] ram_rdata;
    logic [15:0]       frame_len_c;
    logic              oversize_c, last_word_c, in_frame_c;

    assign frame_len_c = {len[15:8], Rx_Data};
    assign oversize_c  = 32'(frame_len_c) > (32'd1 << ADDR_W);
    assign last_word_c = (32'(wr_addr) + 32'd1) == 32'(len);
    assign in_frame_c  = (state == ST_LEN_HI) || (state == ST_LEN_LO) || (state == ST_DATA_HI)
                      || (state == ST_DATA_LO) || (state == ST_CHECK);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state        <= ST_IDLE;
            len          <= '0;
            hi_byte      <= '0;
            csum         <= '0;
            wr_addr      <= '0;
            to_cnt       <= '0;
            Cpu_Hold     <= 1'b1;
            Load_Done    <= 1'b0;
            Load_Error   <= 1'b0;
            Words_Loaded <= '0;
        end else begin
            state        <= state_nxt;
            len          <= len_nxt;
            hi_byte      <= hi_nxt;
            csum         <= csum_nxt;
            wr_addr      <= wr_addr_nxt;
            to_cnt       <= to_cnt_nxt;
            Cpu_Hold     <= hold_nxt;
            Load_Done    <= done_nxt;
            Load_Error   <= err_nxt;
            Words_Loaded <= words_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        len_nxt     = len;
        hi_nxt      = hi_byte;
        csum_nxt    = csum;
        wr_addr_nxt = wr_addr;
        to_cnt_nxt  = to_cnt;
        hold_nxt    = Cpu_Hold;
        done_nxt    = Load_Done;
        err_nxt     = Load_Error;
        words_nxt   = Words_Loaded;
        ram_we_c    = 1'b0;

        case (state)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (Rx_Valid && (Rx_Data == START_BYTE)) begin
                    state_nxt   = ST_LEN_HI;
                    hold_nxt    = 1'b1;
                    done_nxt    = 1'b0;
                    err_nxt     = 1'b0;
                    csum_nxt    = '0;
                    wr_addr_nxt = '0;
                    to_cnt_nxt  = '0;
                end
            end
            ST_LEN_HI: begin
                if (Rx_Valid) begin
                    len_nxt   = {Rx_Data, len[7:0]};
                    csum_nxt  = csum ^ Rx_Data;
                    state_nxt = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (Rx_Valid) begin
                    len_nxt  = frame_len_c;
                    csum_nxt = csum ^ Rx_Data;
                    if (frame_len_c == 16'd0) begin
                        state_nxt = ST_CHECK;
                    end else if (oversize_c) begin
                        state_nxt = ST_ERROR;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (Rx_Valid) begin
                    hi_nxt    = Rx_Data;
                    csum_nxt  = csum ^ Rx_Data;
                    state_nxt = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (Rx_Valid) begin
                    ram_we_c    = 1'b1;
                    wr_addr_nxt = wr_addr + CNT_W'(1);
                    csum_nxt    = csum ^ Rx_Data;
                    state_nxt   = last_word_c ? ST_CHECK : ST_DATA_HI;
                end
            end
            ST_CHECK: begin
                if (Rx_Valid) begin
                    if (Rx_Data == csum) begin
                        state_nxt = ST_RUN;
                        hold_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        words_nxt = CNT_W'(len);
                    end else begin
                        state_nxt = ST_ERROR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Inter-byte watchdog, only armed while a frame is in progress
        if (in_frame_c) begin
            if (Rx_Valid) begin
                to_cnt_nxt = '0;
            end else if (to_cnt == TO_LAST) begin
                state_nxt = ST_ERROR;
                err_nxt   = 1'b1;
            end else begin
                to_cnt_nxt = to_cnt + TO_W'(1);
            end
        end
    end

    bip_prog_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (Clock),
        .we    (ram_we_c),
        .waddr (wr_addr[ADDR_W-1:0]),
        .wdata (DATA_W'({hi_byte, Rx_Data})),
        .raddr (InsAddr),
        .rdata (ram_rdata)
    );

    // The CPU sees NOPs whenever it is held
    assign Instruction = Cpu_Hold ? '0 : ram_rdata;

endmodule

// File: tb/tb_bip_program_loader.sv
// Directed and randomized frame-level bench for the BIP program loader.
module tb_bip_program_loader;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 16;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [7:0]    Rx_Data;
    logic          Rx_Valid;
    logic [AW-1:0] InsAddr;
    logic [DW-1:0] Instruction;
    logic          Cpu_Hold;
    logic          Load_Done;
    logic          Load_Error;
    logic [AW:0]   Words_Loaded;

    int checks = 0;
    int errors = 0;

    logic [7:0]  frm[$];
    logic [15:0] wq[$];

    // Frame-level reference: memory image plus the expected status flags
    logic [15:0] mdl_mem [8];
    bit          mdl_known [8];
    int          mdl_hold, mdl_done, mdl_err, mdl_words;

    always #5 Clock = ~Clock;

    bip_program_loader #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Rx_Data      (Rx_Data),
        .Rx_Valid     (Rx_Valid),
        .InsAddr      (InsAddr),
        .Instruction  (Instruction),
        .Cpu_Hold     (Cpu_Hold),
        .Load_Done    (Load_Done),
        .Load_Error   (Load_Error),
        .Words_Loaded (Words_Loaded)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge Clock);
        Rx_Data  = b;
        Rx_Valid = 1'b1;
        @(negedge Clock);
        Rx_Valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic build_frame(input logic [15:0] n);
        logic [7:0] cs;
        frm = {};
        frm.push_back(8'hA5);
        frm.push_back(n[15:8]);
        frm.push_back(n[7:0]);
        foreach (wq[i]) begin
            frm.push_back(wq[i][15:8]);
            frm.push_back(wq[i][7:0]);
        end
        cs = 8'h00;
        for (int i = 1; i < frm.size(); i++) cs ^= frm[i];
        frm.push_back(cs);
    endtask

    task automatic send_frame(input int count, input int max_gap);
        for (int i = 0; i < count; i++) begin
            send_byte(frm[i]);
            idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic check_status(input string tag, input int hold, input int done,
                                input int err, input int words);
        check({tag, ".hold"},  32'(Cpu_Hold),     32'(hold));
        check({tag, ".done"},  32'(Load_Done),    32'(done));
        check({tag, ".err"},   32'(Load_Error),   32'(err));
        check({tag, ".words"}, 32'(Words_Loaded), 32'(words));
    endtask

    task automatic check_ins(input string tag, input int addr, input logic [15:0] exp);
        InsAddr = AW'(addr);
        #1;
        check(tag, 32'(Instruction), 32'(exp));
    endtask

    task automatic mdl_write(input int count);
        for (int i = 0; i < count && i < 8; i++) begin
            mdl_mem[i]   = wq[i];
            mdl_known[i] = 1'b1;
        end
    endtask

    task automatic random_phase(input int iters);
        int kind, n, k;
        logic [7:0]  b;
        logic [15:0] big;
        for (int it = 0; it < iters; it++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h3C;
                send_byte(b);
            end
            kind = $urandom_range(0, 9);
            n    = $urandom_range(1, 6);
            wq   = {};
            for (int i = 0; i < n; i++) begin
                wq.push_back(($urandom_range(0, 3) == 0) ? 16'hA5A5 : 16'($urandom));
            end
            build_frame(16'(n));
            if (kind == 6) begin
                frm[frm.size() - 1] ^= 8'(1 << $urandom_range(0, 7));
                send_frame(frm.size(), 8);
                mdl_write(n);
                mdl_hold = 1; mdl_done = 0; mdl_err = 1;
            end else if (kind == 7) begin
                big = 16'(2049 + $urandom_range(0, 3000));
                send_byte(8'hA5);
                send_byte(big[15:8]);
                send_byte(big[7:0]);
                mdl_hold = 1; mdl_done = 0; mdl_err = 1;
            end else if (kind == 8) begin
                k = $urandom_range(0, n - 1);
                send_frame(3 + 2 * k + $urandom_range(0, 1), 8);
                idle(TO + 4);
                mdl_write(k);
                mdl_hold = 1; mdl_done = 0; mdl_err = 1;
            end else begin
                send_frame(frm.size(), 8);
                mdl_write(n);
                mdl_hold = 0; mdl_done = 1; mdl_err = 0; mdl_words = n;
            end
            check_status($sformatf("rnd%0d", it), mdl_hold, mdl_done, mdl_err, mdl_words);
            if (mdl_hold == 0) begin
                for (int a = 0; a < 8; a++) begin
                    if (mdl_known[a]) check_ins($sformatf("rnd%0d.ins%0d", it, a), a, mdl_mem[a]);
                end
            end else begin
                check_ins($sformatf("rnd%0d.nop", it), $urandom_range(0, 7), 16'h0000);
            end
        end
    endtask

    initial begin
        Reset    = 1'b0;
        Rx_Data  = 8'h00;
        Rx_Valid = 1'b0;
        InsAddr  = '0;
        idle(3);
        check_status("reset", 1, 0, 0, 0);
        check_ins("reset.nop", 0, 16'h0000);
        @(negedge Clock);
        Reset = 1'b1;
        idle(2);

        // Good load
        wq = {16'h1855, 16'h0801, 16'h2807};
        build_frame(16'd3);
        check("t1.csum_byte", 32'(frm[frm.size() - 1]), 32'h68);
        send_frame(frm.size(), 3);
        check_status("t1", 0, 1, 0, 3);
        check_ins("t1.ins0", 0, 16'h1855);
        check_ins("t1.ins1", 1, 16'h0801);
        check_ins("t1.ins2", 2, 16'h2807);

        // Bad checksum
        frm[frm.size() - 1] = 8'h69;
        send_frame(frm.size(), 3);
        check_status("t2", 1, 0, 1, 3);
        for (int a = 0; a < 3; a++) check_ins($sformatf("t2.nop%0d", a), a, 16'h0000);

        // Empty frame, then oversize length
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check_status("t3.empty", 0, 1, 0, 0);
        send_byte(8'hA5); send_byte(8'h08);
        check("t3.before_lo", 32'(Load_Error), 32'd0);
        send_byte(8'h01);
        check_status("t3.oversize", 1, 0, 1, 0);

        // Exactly 2**ADDR_W words is legal; abandon it to the watchdog
        send_byte(8'hA5); send_byte(8'h08); send_byte(8'h00);
        check_status("t3.maxlen", 1, 0, 0, 0);
        idle(TO + 2);
        check("t3.maxlen_to", 32'(Load_Error), 32'd1);

        // Timeout lands exactly TO cycles after the last strobe
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h18);
        idle(TO - 1);
        check("t4.pre", 32'(Load_Error), 32'd0);
        idle(1);
        check_status("t4.timeout", 1, 0, 1, 0);

        // Noise in RUN, then restart and a one-word reload
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h3C);
        check_status("t5.noise", 0, 1, 0, 0);
        send_byte(8'hA5);
        check("t5.hold", 32'(Cpu_Hold), 32'd1);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h67);
        check_status("t5.reload", 0, 1, 0, 1);
        check_ins("t5.ins0", 0, 16'hABCD);

        // Reset between DATA_HI and DATA_LO
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'hAB);
        Reset = 1'b0;
        #2;
        check_status("t6.reset", 1, 0, 0, 0);
        @(negedge Clock);
        Reset = 1'b1;
        idle(1);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h27);
        check_status("t6.load", 0, 1, 0, 1);
        check_ins("t6.ins0", 0, 16'h1234);

        // Randomized frames against the frame-level model
        for (int a = 0; a < 8; a++) mdl_known[a] = 1'b0;
        mdl_hold = 0; mdl_done = 1; mdl_err = 0; mdl_words = 1;
        random_phase(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
